// File: rtl/inst_fetch_pkg.sv
// Shared cpu definitions: word-address width, boot PC,
// fetch state encoding and the IF/ID bundle used by decode.
package inst_fetch_pkg;

  localparam int unsigned AW = 30;
  localparam int unsigned IW = 32;

  localparam logic [AW-1:0] BOOT_PC_DEF = 30'h0000_0c00;

  localparam logic [2:0] S_WAIT_PC = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  typedef enum logic [2:0] {
    WAIT_PC = S_WAIT_PC,
    REQ     = S_REQ,
    DRAIN   = S_DRAIN,
    HOLD    = S_HOLD,
    ERR     = S_ERR
  } fstate_e;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } if_id_t;

endpackage

// File: rtl/inst_fetch_timer.sv
// Bus-wait counter: clear, count up, flag terminal count.
// Also used by the data-memory stage.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = 8'd0;
    else if (inc_i)
      cnt_d = cnt_q + 8'd1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: drives the PC register, reads one word per
// PC load over imem, and holds it in the IF/ID register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [29:0] BOOT_PC = BOOT_PC_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] pc_in,
  input  logic        pc_work,
  output logic        pc_wr,
  output logic [29:0] next_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [29:0] id_pc,
  input  logic        id_ready,
  input  logic        flush,
  input  logic [29:0] flush_pc,
  output logic        fetch_err
);

  fstate_e     state_q;
  logic [29:0] npc_q;
  logic [29:0] addr_q;
  if_id_t      ifid_q;
  logic        tmo;

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == WAIT_PC),
    .inc_i (state_q == REQ || state_q == DRAIN),
    .tc_o  (tmo)
  );

  // fetch sequencer: PC handshake, bus read, IF/ID hand-off
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_PC;
      npc_q   <= BOOT_PC;
      addr_q  <= '0;
      ifid_q  <= '0;
    end else begin
      case (state_q)
        WAIT_PC: begin
          if (flush) begin
            npc_q <= flush_pc;
          end else if (pc_work && pc_in == npc_q) begin
            addr_q  <= pc_in;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (flush) begin
              npc_q   <= flush_pc;
              state_q <= WAIT_PC;
            end else begin
              ifid_q.inst <= imem_rdata;
              ifid_q.pc   <= addr_q;
              state_q     <= HOLD;
            end
          end else if (tmo) begin
            state_q <= ERR;
          end else if (flush) begin
            npc_q   <= flush_pc;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush)
            npc_q <= flush_pc;
          if (imem_ack)
            state_q <= WAIT_PC;
          else if (tmo)
            state_q <= ERR;
        end
        HOLD: begin
          if (flush) begin
            npc_q   <= flush_pc;
            state_q <= WAIT_PC;
          end else if (id_ready) begin
            npc_q   <= ifid_q.pc + 30'd1;
            state_q <= WAIT_PC;
          end
        end
        ERR: state_q <= ERR;
        default: state_q <= ERR;
      endcase
    end
  end

  assign pc_wr     = (state_q == WAIT_PC);
  assign next_pc   = npc_q;
  assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr = addr_q;
  assign id_valid  = (state_q == HOLD);
  assign id_inst   = ifid_q.inst;
  assign id_pc     = ifid_q.pc;
  assign fetch_err = (state_q == ERR);

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly downstream of the PC register. Drives pc_wr/next_pc back into it and consumes pc_out/pc_work from it.
- Reads one instruction word per PC load over a req/ack instruction-memory port.
- Holds the word, with its PC, in a one-entry IF/ID register handed to decode under valid/ready.
- Handles branch flush, including flush during an outstanding bus read, and a bus-timeout error.

Parameters:
BOOT_PC, 30'h0000_0c00, first word address requested after reset (PC reset value 30'hbff + 1)
TIMEOUT, 64, cycles an imem read may stay unacknowledged before fetch_err (2..255)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
pc_in  in  30  [31:2] current PC value (from PC pc_out)
pc_work  in  1  PC loaded a new value last edge
pc_wr  out  1  request PC to load next_pc
next_pc  out  30  [31:2] address for PC to load
imem_req  out  1  read request, held until imem_ack
imem_addr  out  30  [31:2] word address, stable while imem_req=1
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
id_valid  out  1  IF/ID register holds a valid instruction
id_inst  out  32  instruction word
id_pc  out  30  [31:2] address of id_inst
id_ready  in  1  decode accepts id_inst this cycle
flush  in  1  redirect fetch (branch/jump/exception)
flush_pc  in  30  [31:2] redirect target
fetch_err  out  1  sticky imem timeout

Behaviour:
- Registers:
  - state: WAIT_PC, REQ, DRAIN, HOLD, ERR
  - npc_q: 30 bits
  - addr_q: 30 bits
  - id_inst/id_pc registers
  - tcnt: 8-bit timeout counter
- Reset values:
  - state=WAIT_PC, npc_q=BOOT_PC
  - imem_req=0, id_valid=0, id_inst=0, id_pc=0, fetch_err=0, tcnt=0
  - pc_wr=1 after reset because it is decoded from WAIT_PC.
  - Reset mid-transaction drops imem_req immediately; the bus tolerates the abandoned request.
- Moore-decoded outputs:
  - pc_wr = (state==WAIT_PC); next_pc = npc_q
  - imem_req = (state==REQ | state==DRAIN); imem_addr = addr_q
  - id_valid = (state==HOLD); fetch_err = (state==ERR)
- WAIT_PC:
  - flush: npc_q<=flush_pc, stay.
  - else pc_work & pc_in==npc_q: addr_q<=pc_in, tcnt<=0 -> REQ.
  - pc_work with mismatching pc_in (stale load) is ignored.
  - pc_wr stays high until the matching load is seen. If PC is disabled (pc_en=0), the block simply waits.
- REQ:
  - imem_ack & !flush: id_inst<=imem_rdata, id_pc<=addr_q -> HOLD. id_valid rises one cycle after ack.
  - imem_ack & flush: discard data, npc_q<=flush_pc -> WAIT_PC.
  - flush & !ack: npc_q<=flush_pc -> DRAIN.
  - no ack & tcnt==TIMEOUT-1 -> ERR; else tcnt++.
  - Ack on the final timeout cycle wins over the timeout.
- DRAIN: the bus read completes, but its data is discarded.
  - flush: npc_q<=flush_pc (latest target wins).
  - imem_ack -> WAIT_PC.
  - Timeout rule identical to REQ.
- HOLD:
  - flush (priority over id_ready): npc_q<=flush_pc -> WAIT_PC; the instruction is dropped.
  - id_ready: npc_q<=id_pc+1 -> WAIT_PC.
  - otherwise hold id_inst/id_pc stable.
- ERR: all requests low, id_valid=0. Stays until reset; flush ignored.
- Arithmetic: id_pc+1 is 30-bit modulo (30'h3fffffff -> 0).
- Throughput (zero-wait memory, decode always ready):
  - One instruction per 4 cycles: WAIT_PC, REQ, HOLD, plus the PC load edge.
  - Throughput is not a goal of this block.

Decomposition:
- Shared cpu package holds:
  - state encoding localparams (3 bits)
  - BOOT_PC default and word-address width (30)
  - the IF/ID bundle field widths, also used by decode
- One sub-module: fetch_timer, which clears, increments and flags terminal count at TIMEOUT-1. The same counter is reused later by the data-memory stage.

Test Plan:
- Boot: reset 3 cycles, PC model loads, imem acks after 2 cycles with 32'h2408_0001 -> first imem_addr=30'hc00; id_valid with id_inst=32'h2408_0001, id_pc=30'hc00; next pc_wr carries next_pc=30'hc01.
- Decode stall: id_ready=0 for 5 cycles in HOLD -> id_inst/id_pc constant, pc_wr=0, imem_req=0; id_ready=1 -> next cycle pc_wr=1, next_pc=id_pc+1.
- Flush during REQ: flush_pc=30'h100 two cycles before ack, second flush 30'h200 in DRAIN -> ack data never reaches id_valid; then next_pc=30'h200, imem_addr=30'h200.
- Flush same cycle as id_ready in HOLD -> next_pc=flush_pc, not id_pc+1; no valid instruction handed over twice.
- Timeout: no ack for 64 cycles -> fetch_err=1 on cycle 65, imem_req=0, flush ignored; reset clears it and pc_wr=1 with next_pc=30'hc00. Ack on cycle 64 -> no error.
- Wrap and stale load: id_pc=30'h3fffffff accepted -> next_pc=0. pc_work with pc_in != npc_q in WAIT_PC -> no request issued.
